// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: bit order, blank pattern and hex glyph table.
package ssd_pkg;

  // Segment bit positions within a 7-bit pattern {g,f,e,d,c,b,a}
  typedef enum int unsigned {
    SEG_A = 0, SEG_B = 1, SEG_C = 2, SEG_D = 3, SEG_E = 4, SEG_F = 5, SEG_G = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high glyphs, entry [n] is hex digit n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Nibble to active-high seven-segment glyph.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = seg_encode(i_nibble);

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit display scanner with blanking, zero suppression and
// frame-synchronous double-buffered updates.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_lz_blank,
  input  logic                    i_load,
  output logic [6:0]              o_segments,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_dig_sel,
  output logic                    o_frame_start,
  output logic                    o_pending
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [TW-1:0]         r_tick;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_sh_val, r_act_val;
  logic [NUM_DIGITS-1:0] r_sh_dp, r_sh_en, r_act_dp, r_act_en;
  logic                  r_pending;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_sel;
  logic                  r_fs;

  logic                  w_tick_last, w_boundary;
  logic [VW-1:0]         w_upper;
  logic [3:0]            w_nib;
  logic [6:0]            w_pat;
  logic                  w_in_blank, w_supp, w_dark;

  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_boundary  = w_tick_last && (r_idx == IDX_LAST);

  // Current nibble and everything above it; all-zero means a leading zero
  assign w_upper    = r_act_val >> {r_idx, 2'b00};
  assign w_nib      = w_upper[3:0];
  assign w_in_blank = (BLANK_TICKS > 0) && (r_tick < BLANK_END);
  assign w_supp     = i_lz_blank && (r_idx != '0) && (w_upper == '0);
  assign w_dark     = w_in_blank || !r_act_en[r_idx] || w_supp;

  ssd_hex_decode u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_pat)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else if (w_tick_last) begin
      r_tick <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the shadow so it is never a frame late
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_sh_en   <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_act_en  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh_val <= i_value;
        r_sh_dp  <= i_dp_in;
        r_sh_en  <= i_digit_en;
      end
      if (w_boundary && i_load) begin
        r_act_val <= i_value;
        r_act_dp  <= i_dp_in;
        r_act_en  <= i_digit_en;
        r_pending <= 1'b0;
      end else if (w_boundary && r_pending) begin
        r_act_val <= r_sh_val;
        r_act_dp  <= r_sh_dp;
        r_act_en  <= r_sh_en;
        r_pending <= 1'b0;
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
      r_sel <= '1;
      r_fs  <= 1'b0;
    end else begin
      r_seg <= w_dark ? SEG_OFF : ~w_pat;
      r_dp  <= w_dark ? 1'b1 : ~r_act_dp[r_idx];
      r_sel <= w_dark ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_fs  <= (r_tick == '0) && (r_idx == '0);
    end
  end

  assign o_segments    = r_seg;
  assign o_dp          = r_dp;
  assign o_dig_sel     = r_sel;
  assign o_frame_start = r_fs;
  assign o_pending     = r_pending;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized and directed bench for ssd_scan_driver against a cycle-count reference model.
module tb_ssd_scan_driver;

  localparam int N = 4;
  localparam int D = 8;
  localparam int B = 2;
  localparam int F = N * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_start;
  logic        pending;

  ssd_scan_driver #(.NUM_DIGITS(N), .DIGIT_TICKS(D), .BLANK_TICKS(B)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_value       (value),
    .i_dp_in       (dp_in),
    .i_digit_en    (digit_en),
    .i_lz_blank    (lz),
    .i_load        (load),
    .o_segments    (segments),
    .o_dp          (dp),
    .o_dig_sel     (dig_sel),
    .o_frame_start (frame_start),
    .o_pending     (pending)
  );

  always #5 clk = ~clk;

  // Glyphs 0..F written out independently of the design package
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad   = 0;

  // Model: cycles since reset release plus the two register banks
  int          t;
  logic [15:0] m_act_val, m_sh_val;
  logic [3:0]  m_act_dp, m_sh_dp, m_act_en, m_sh_en;
  logic        m_pend;
  int          cyc_no = 0;
  int          last_fs = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_act_val = '0; m_sh_val = '0;
    m_act_dp  = '0; m_sh_dp  = '0;
    m_act_en  = '0; m_sh_en  = '0;
    m_pend    = 1'b0;
    last_fs   = -1;
  endtask

  task automatic rst_cyc();
    rst_n = 1'b0;
    @(posedge clk); #1;
    cyc_no++;
    model_reset();
    chk("rst_seg", 32'(segments), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_sel", 32'(dig_sel), 32'hF);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
  endtask

  task automatic cyc();
    int slot, ph;
    bit dark, upz;
    logic [3:0] nib;
    logic [6:0] es;
    logic       ed, efs;
    logic [3:0] esel;
    slot = (t / D) % N;
    ph   = t % D;
    upz  = 1'b1;
    for (int j = slot; j < N; j++) if (m_act_val[j*4 +: 4] != 4'h0) upz = 1'b0;
    nib  = m_act_val[slot*4 +: 4];
    dark = (ph < B) || !m_act_en[slot] || (lz && slot != 0 && upz);
    es   = dark ? 7'h7F : ~glyph[nib];
    ed   = dark ? 1'b1 : ~m_act_dp[slot];
    esel = dark ? 4'hF : ~(4'b0001 << slot);
    efs  = (t % F) == 0;
    if ((t % F) == F - 1) begin
      if (load) begin
        m_act_val = value; m_act_dp = dp_in; m_act_en = digit_en;
      end else if (m_pend) begin
        m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
      end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin
      m_sh_val = value; m_sh_dp = dp_in; m_sh_en = digit_en;
    end
    t++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc_no++;
    chk("seg", 32'(segments), 32'(es));
    chk("dp", 32'(dp), 32'(ed));
    chk("sel", 32'(dig_sel), 32'(esel));
    chk("fs", 32'(frame_start), 32'(efs));
    chk("pend", 32'(pending), 32'(m_pend));
    if (frame_start) begin
      if (last_fs >= 0) chk("fs_period", 32'(cyc_no - last_fs), 32'(F));
      last_fs = cyc_no;
    end
  endtask

  // Run until the next cyc() will evaluate frame phase p
  task automatic run_to(input int p);
    while ((t % F) != p) cyc();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value = v; dp_in = d; digit_en = e; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    // Reset, run into a slot, then reset again mid-slot for 3 cycles
    rst_cyc(); rst_cyc();
    repeat (13) cyc();
    repeat (3) rst_cyc();

    // Decode
    run_to(5);
    do_load(16'h12AF, 4'b0001, 4'hF);
    chk("pend_after_load", 32'(pending), 32'h1);
    run_to(0);
    run_to(2);  cyc();
    chk("dec_d0_seg", 32'(segments), 32'h0E);
    chk("dec_d0_dp", 32'(dp), 32'h0);
    chk("dec_d0_sel", 32'(dig_sel), 32'hE);
    run_to(26); cyc();
    chk("dec_d3_seg", 32'(segments), 32'h79);
    repeat (2 * F) cyc();

    // Leading-zero suppression
    lz = 1'b1;
    run_to(4);
    do_load(16'h0050, 4'b0000, 4'hF);
    run_to(0);
    run_to(10); cyc();
    chk("lz_d1", 32'(segments), 32'h12);
    run_to(18); cyc();
    chk("lz_d2_dark", 32'(dig_sel), 32'hF);
    run_to(2);  cyc();
    chk("lz_d0", 32'(segments), 32'h40);
    run_to(8);
    do_load(16'h0000, 4'b0000, 4'hF);
    repeat (2 * F) cyc();
    lz = 1'b0;

    // Tear-free update: two loads mid-frame, last wins at the boundary
    run_to(5);
    do_load(16'h1111, 4'b0000, 4'hF);
    cyc();
    do_load(16'h2222, 4'b0000, 4'hF);
    run_to(10); cyc();
    chk("tear_old", 32'(segments), 32'h40);
    chk("tear_pend", 32'(pending), 32'h1);
    run_to(2);  cyc();
    chk("tear_new", 32'(segments), 32'h24);
    chk("tear_pend_clr", 32'(pending), 32'h0);

    // Load exactly on the boundary
    run_to(F - 1);
    do_load(16'h3333, 4'b0000, 4'hF);
    chk("bnd_pend", 32'(pending), 32'h0);
    run_to(2);  cyc();
    chk("bnd_seg", 32'(segments), 32'h30);

    // Per-digit enable
    run_to(6);
    do_load(16'h4567, 4'b1010, 4'b0101);
    repeat (3 * F) cyc();

    // Random traffic, occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) lz = ~lz;
      if ($urandom_range(0, 699) == 0) begin
        repeat ($urandom_range(1, 3)) rst_cyc();
      end
      if ($urandom_range(0, 15) == 0) begin
        value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
        if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
        load = 1'b1;
      end
      cyc();
      load = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Multiplexed N-digit seven-segment display driver. Holds a packed hex value, decodes each nibble to segments, and scans the common digit selects round-robin at a parameter-set rate. Adds what the single-digit decoder lacks: anti-ghost blanking between slots, leading-zero suppression, per-digit enable and decimal points, and tear-free frame-synchronous updates through a load handshake. Sits between application logic and the board's display pins.

## Interface
- NUM_DIGITS, 4: digits scanned, at least 1.
- DIGIT_TICKS, 50000: clock cycles per digit slot, at least 2.
- BLANK_TICKS, 500: cycles at the start of each slot with all selects inactive. Must be less than DIGIT_TICKS; 0 is legal.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- value  in  4*NUM_DIGITS  hex digits; nibble i drives digit i; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable; 1 = shown.
- lz_blank  in  1  leading-zero suppression enable; sampled live, not via load.
- load  in  1  one-cycle strobe; captures value, dp_in and digit_en.
- segments  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- dig_sel  out  NUM_DIGITS  active-low digit selects.
- frame_start  out  1  one-cycle pulse on the first output cycle of the digit 0 slot.
- pending  out  1  a loaded value is waiting for the next frame boundary.

## Operation
- tick_cnt counts 0 to DIGIT_TICKS-1. At terminal count it wraps and digit index idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle with idx = NUM_DIGITS-1 and tick_cnt = DIGIT_TICKS-1.
- Registers:
  - Shadow register takes the inputs on load. Back-to-back loads overwrite it; the last load wins. load sets pending.
  - Active register copies the shadow at the frame boundary if pending is set, then pending clears.
  - If load coincides with the boundary, the load inputs go straight to active and pending stays 0.
- Decode from the active register, active-high before inversion: 0-F = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 67, 77, 7C, 39, 5E, 79, 71 (hex).
- Leading-zero suppression (lz_blank = 1): a digit is suppressed when its nibble and every higher-index nibble are 0. Digit 0 is never suppressed.
- Current digit is dark when any of these holds: tick_cnt < BLANK_TICKS, digit_en[idx] = 0, or the digit is suppressed.
  - Dark means dig_sel all 1s, segments 7'h7F, dp 1.
  - Otherwise dig_sel has only bit idx at 0, segments = ~decode, dp = ~dp_in[idx].
- A dark slot still takes its full DIGIT_TICKS, so frame period and duty stay constant.

## Timing
- Reset values:
  - Outputs: segments 7'h7F, dp 1, dig_sel all 1s, frame_start 0, pending 0.
  - State: tick_cnt 0, idx 0, shadow and active registers 0.
- Reset taken mid-slot or mid-frame aborts the scan immediately; the next cycle shows the reset values.
- All outputs are registered. The output in cycle k reflects the counter and active state of cycle k-1.
- After rst_n rises, the first output cycle is blanked if BLANK_TICKS > 0. dig_sel[0] first goes low BLANK_TICKS+1 cycles after release.
- Frame period is NUM_DIGITS*DIGIT_TICKS cycles. frame_start repeats at exactly that period, and the first frame_start occurs one cycle after reset release.
- A new value is first visible in the frame_start cycle that follows the boundary where it transferred.
- lz_blank changes take effect with the normal 1-cycle registered latency.

## Structure
- Shared package ssd_pkg holds: the 16-entry segment encoding constant, SEG_OFF = 7'h7F, and the segment bit-order definition. Future display blocks reuse these.
- One combinational sub-module, ssd_hex_decode: 4-bit nibble to 7-bit active-high pattern, instanced once on the muxed nibble.
- Scan counters, load and shadow logic, suppression and output registers live in the top module.

## Test plan
All scenarios use NUM_DIGITS=4, DIGIT_TICKS=8, BLANK_TICKS=2.
- Reset: hold rst_n low 3 cycles mid-slot, then release.
  - During reset: segments 7'h7F, dp 1, dig_sel 4'hF, pending 0.
  - After release: dig_sel = 4'hE first appears 3 cycles after release.
- Decode: load value 16'h12AF, dp_in 4'b0001, digit_en 4'hF.
  - From the next frame: digit 0 shows segments 7'h0E with dp 0; digit 3 shows 7'h79.
  - Each select is low 6 of 8 cycles; frame_start period is 32 cycles.
- Leading-zero suppression: lz_blank=1, value 16'h0050.
  - Digits 3 and 2 are dark for the whole slot; digit 1 shows 7'h12; digit 0 shows 7'h40.
  - With value 16'h0000, only digit 0 is lit (7'h40).
- Tear-free update: load 16'h1111 mid-frame, then 16'h2222 two cycles later.
  - The current frame keeps showing the old value; the next frame shows all 2s (7'h24).
  - pending is high from the first load until the boundary.
- Boundary load: assert load with 16'h3333 exactly on the boundary cycle.
  - The immediately following frame shows 3s (7'h30); pending never rises.
- Digit enable: digit_en 4'b0101.
  - dig_sel[1] and dig_sel[3] never go low.
  - The digit 0 slot still starts every 32 cycles.
